// File: rtl/stimulus_player_if.sv
// stimulus_player_if: valid/ready packet port between the
// stimulus player (master) and the device under test (slave).
`timescale 1ns/1ps
interface stimulus_player_if #(
  parameter int DW = 64
);
  logic          stim_valid;
  logic [DW-1:0] stim_packet;
  logic          dut_ready;

  modport master (
    output stim_valid,
    output stim_packet,
    input  dut_ready
  );

  modport slave (
    input  stim_valid,
    input  stim_packet,
    output dut_ready
  );
endinterface

// File: rtl/stimulus_player.sv
// stimulus_player: RAM-backed packet replayer with per-entry gaps
// and one-shot / loop / single-step playback on a valid/ready port.
`timescale 1ns/1ps
module stimulus_player #(
  parameter  int DW    = 64,
  parameter  int DEPTH = 1024,
  parameter  int CW    = 8,
  parameter  int RW    = 16,
  localparam int MW    = DW + CW + 1,
  localparam int MAW   = $clog2(DEPTH)
) (
  input  logic              ext_clk,
  input  logic              nreset,
  input  logic              ext_access,
  input  logic [MW-1:0]     ext_packet,
  input  logic              ext_clear,
  input  logic              ext_start,
  input  logic              ext_abort,
  input  logic [1:0]        ext_mode,
  input  logic [RW-1:0]     ext_repeat,
  stimulus_player_if.master stim,
  output logic              stim_busy,
  output logic              stim_done,
  output logic [RW-1:0]     stim_pass_count,
  output logic [MAW:0]      wr_count
);

  localparam int DLW = (CW > 0) ? CW : 1;
  localparam logic [MAW:0] FULL = (MAW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DRIVE, S_HOLD, S_DONE
  } state_t;

  state_t state, state_d;

  logic [MW-1:0]  ram [DEPTH];
  logic [MW-1:0]  ram_q;
  logic [MAW-1:0] rd_addr, rd_addr_d;
  logic [DLW-1:0] wait_cnt;
  logic [DW-1:0]  pkt_q;
  logic [1:0]     mode_q;
  logic [RW-1:0]  rep_q;
  logic           start_q;

  logic           start_edge, idle_like;
  logic           loop_on, last_ent, wr_en;
  logic           ent_valid;
  logic [DLW-1:0] ent_delay;
  logic [DW-1:0]  ent_data;
  logic           cfg_ld, arm, wrap, rd_inc;
  logic           pass_inc, ent_ld, wait_ld;

  assign ent_valid = ram_q[0];
  assign ent_data  = ram_q[MW-1:CW+1];

  generate
    if (CW > 0) begin : g_dly
      assign ent_delay = ram_q[CW:1];
    end else begin : g_nodly
      assign ent_delay = '0;
    end
  endgenerate

  assign start_edge = ext_start & ~start_q;
  assign idle_like  = (state == S_IDLE) ||
                      (state == S_DONE);
  assign last_ent   = ({1'b0, rd_addr} + (MAW+1)'(1))
                      == wr_count;
  assign loop_on    = (mode_q == 2'b01) &&
                      ((rep_q == '0) ||
                       (({1'b0, stim_pass_count} + (RW+1)'(1))
                        < {1'b0, rep_q}));
  assign wr_en      = idle_like & ext_access &
                      ~ext_clear & (wr_count != FULL);

  assign stim.stim_valid  = (state == S_DRIVE);
  assign stim.stim_packet = pkt_q;
  assign stim_busy        = ~idle_like;
  assign stim_done        = (state == S_DONE);

  always_ff @(posedge ext_clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d  = state;
    cfg_ld   = 1'b0;
    arm      = 1'b0;
    wrap     = 1'b0;
    rd_inc   = 1'b0;
    pass_inc = 1'b0;
    ent_ld   = 1'b0;
    wait_ld  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          cfg_ld = 1'b1;
          if (wr_count == '0) begin
            state_d = S_DONE;
          end else begin
            arm     = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (!ent_valid) begin
          pass_inc = 1'b1;
          wrap     = loop_on;
          state_d  = loop_on ? S_FETCH : S_DONE;
        end else begin
          ent_ld = 1'b1;
          if (ent_delay != '0) begin
            wait_ld = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_DRIVE;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == DLW'(1)) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (stim.dut_ready) begin
          rd_inc = 1'b1;
          if (last_ent) begin
            pass_inc = 1'b1;
            wrap     = loop_on;
            state_d  = loop_on ? S_FETCH : S_DONE;
          end else if (mode_q == 2'b10) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HOLD: begin
        if (start_edge) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides any handshake or step edge this cycle
    if (ext_abort && !idle_like) begin
      state_d  = S_DONE;
      wrap     = 1'b0;
      rd_inc   = 1'b0;
      pass_inc = 1'b0;
      ent_ld   = 1'b0;
      wait_ld  = 1'b0;
    end
  end

  always_comb begin
    rd_addr_d = rd_addr;
    if (arm || wrap) rd_addr_d = '0;
    else if (rd_inc) rd_addr_d = rd_addr + MAW'(1);
  end

  // read uses the next address so the entry is ready during FETCH
  always_ff @(posedge ext_clk) begin
    if (wr_en) ram[wr_count[MAW-1:0]] <= ext_packet;
    ram_q <= ram[rd_addr_d];
  end

  always_ff @(posedge ext_clk or negedge nreset) begin
    if (!nreset) begin
      start_q         <= 1'b0;
      mode_q          <= '0;
      rep_q           <= '0;
      rd_addr         <= '0;
      stim_pass_count <= '0;
      wait_cnt        <= '0;
      pkt_q           <= '0;
      wr_count        <= '0;
    end else begin
      start_q <= ext_start;
      rd_addr <= rd_addr_d;
      if (cfg_ld) begin
        mode_q <= ext_mode;
        rep_q  <= ext_repeat;
      end
      if (arm)
        stim_pass_count <= '0;
      else if (pass_inc && stim_pass_count != '1)
        stim_pass_count <= stim_pass_count + RW'(1);
      if (wait_ld)
        wait_cnt <= ent_delay;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt - DLW'(1);
      if (ent_ld) pkt_q <= ent_data;
      if (idle_like) begin
        if (ext_clear)  wr_count <= '0;
        else if (wr_en) wr_count <= wr_count + (MAW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_stimulus_player.sv
// tb_stimulus_player: directed scenarios with a payload scoreboard
// fed at stimulus time and drained on each valid/ready handshake.
`timescale 1ns/1ps
module tb_stimulus_player;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int RW    = 8;
  localparam int MW    = DW + CW + 1;
  localparam int MAW   = $clog2(DEPTH);

  logic          ext_clk = 1'b0;
  logic          nreset  = 1'b0;
  logic          ext_access = 1'b0;
  logic [MW-1:0] ext_packet = '0;
  logic          ext_clear = 1'b0;
  logic          ext_start = 1'b0;
  logic          ext_abort = 1'b0;
  logic [1:0]    ext_mode = '0;
  logic [RW-1:0] ext_repeat = '0;
  logic          stim_busy, stim_done;
  logic [RW-1:0] stim_pass_count;
  logic [MAW:0]  wr_count;

  stimulus_player_if #(.DW(DW)) u_if ();

  stimulus_player #(
    .DW(DW), .DEPTH(DEPTH), .CW(CW), .RW(RW)
  ) u_dut (
    .ext_clk         (ext_clk),
    .nreset          (nreset),
    .ext_access      (ext_access),
    .ext_packet      (ext_packet),
    .ext_clear       (ext_clear),
    .ext_start       (ext_start),
    .ext_abort       (ext_abort),
    .ext_mode        (ext_mode),
    .ext_repeat      (ext_repeat),
    .stim            (u_if.master),
    .stim_busy       (stim_busy),
    .stim_done       (stim_done),
    .stim_pass_count (stim_pass_count),
    .wr_count        (wr_count)
  );

  always #5 ext_clk = ~ext_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int n_vld   = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_cyc[$];

  always @(posedge ext_clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge ext_clk) begin
    if (nreset && u_if.stim_valid) n_vld++;
    if (nreset && u_if.stim_valid && u_if.dut_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 64'(u_if.stim_packet), 64'hx);
      end else begin
        check("sb_data", 64'(u_if.stim_packet),
              64'(exp_q.pop_front()));
      end
      acc_cyc.push_back(cyc);
      n_acc++;
    end
  end

  function automatic logic [MW-1:0] ent(input logic v,
                                        input int d,
                                        input int data);
    return {DW'(data), CW'(d), v};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge ext_clk);
    #1;
  endtask

  task automatic clear();
    ext_clear = 1'b1;
    tick(1);
    ext_clear = 1'b0;
  endtask

  task automatic load(input logic [MW-1:0] e);
    ext_access = 1'b1;
    ext_packet = e;
    tick(1);
    ext_access = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input int r);
    ext_mode   = m;
    ext_repeat = RW'(r);
    ext_start  = 1'b1;
    tick(1);
    ext_start  = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!stim_done && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(stim_done), 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!u_if.stim_valid && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(u_if.stim_valid), 1);
  endtask

  initial begin
    int base;
    int hold_ok;
    u_if.dut_ready = 1'b0;
    tick(3);
    check("rst_valid", 64'(u_if.stim_valid), 0);
    check("rst_packet", 64'(u_if.stim_packet), 0);
    check("rst_busy", 64'(stim_busy), 0);
    check("rst_done", 64'(stim_done), 0);
    check("rst_pass", 64'(stim_pass_count), 0);
    check("rst_wrcnt", 64'(wr_count), 0);
    nreset = 1'b1;
    tick(2);

    // one-shot, four packets, ready always high
    for (int i = 1; i <= 4; i++) load(ent(1'b1, 0, i));
    check("s1_wrcnt", 64'(wr_count), 4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    u_if.dut_ready = 1'b1;
    acc_cyc.delete();
    n_vld = 0;
    run(2'b00, 0);
    wait_done("s1_done", 50);
    check("s1_pass", 64'(stim_pass_count), 1);
    check("s1_left", 64'(exp_q.size()), 0);
    check("s1_nacc", 64'(acc_cyc.size()), 4);
    check("s1_vcyc", 64'(n_vld), 4);
    if (acc_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        check("s1_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 2);
    end

    // per-entry delay, then back-pressure in DRIVE
    clear();
    load(ent(1'b1, 0, 1));
    load(ent(1'b1, 3, 2));
    load(ent(1'b1, 0, 3));
    for (int i = 1; i <= 3; i++) exp_q.push_back(DW'(i));
    acc_cyc.delete();
    run(2'b00, 0);
    wait_done("s2_done", 50);
    if (acc_cyc.size() >= 3) begin
      check("s2_gap_dly", 64'(acc_cyc[1] - acc_cyc[0]), 5);
      check("s2_gap_nodly", 64'(acc_cyc[2] - acc_cyc[1]), 2);
    end
    check("s2_nacc", 64'(acc_cyc.size()), 3);
    u_if.dut_ready = 1'b0;
    for (int i = 1; i <= 3; i++) exp_q.push_back(DW'(i));
    base = n_acc;
    run(2'b00, 0);
    wait_valid("s2_valid", 20);
    hold_ok = 0;
    for (int i = 0; i < 5; i++) begin
      if (u_if.stim_valid && u_if.stim_packet == DW'(1))
        hold_ok++;
      tick(1);
    end
    check("s2_hold", 64'(hold_ok), 5);
    u_if.dut_ready = 1'b1;
    wait_done("s2_done_bp", 50);
    check("s2_bp_nacc", 64'(n_acc - base), 3);
    check("s2_bp_left", 64'(exp_q.size()), 0);

    // loop mode, three passes then infinite
    clear();
    load(ent(1'b1, 0, 1));
    load(ent(1'b1, 0, 2));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(DW'(1));
      exp_q.push_back(DW'(2));
    end
    run(2'b01, 3);
    wait_done("s3_done", 100);
    check("s3_pass", 64'(stim_pass_count), 3);
    check("s3_left", 64'(exp_q.size()), 0);
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(DW'(1));
      exp_q.push_back(DW'(2));
    end
    run(2'b01, 0);
    base = 0;
    while (exp_q.size() != 0 && base < 1000) begin
      tick(1);
      base++;
    end
    u_if.dut_ready = 1'b0;
    check("s3_inf_left", 64'(exp_q.size()), 0);
    check("s3_inf_pass", 64'(stim_pass_count), 100);
    check("s3_inf_busy", 64'(stim_busy), 1);
    wait_valid("s3_inf_valid", 10);
    ext_abort = 1'b1;
    tick(1);
    ext_abort = 1'b0;
    check("s3_abort_valid", 64'(u_if.stim_valid), 0);
    check("s3_abort_done", 64'(stim_done), 1);
    check("s3_abort_pass", 64'(stim_pass_count), 100);
    u_if.dut_ready = 1'b1;

    // invalid entry terminates the pass early
    clear();
    load(ent(1'b1, 0, 1));
    load(ent(1'b0, 0, 2));
    load(ent(1'b1, 0, 3));
    load(ent(1'b1, 0, 4));
    exp_q.push_back(DW'(1));
    base = n_acc;
    run(2'b00, 0);
    wait_done("s4_done", 50);
    check("s4_nacc", 64'(n_acc - base), 1);
    check("s4_pass", 64'(stim_pass_count), 1);

    // single-step: one packet per start rising edge
    clear();
    for (int i = 1; i <= 3; i++) load(ent(1'b1, 0, i));
    for (int i = 1; i <= 3; i++) exp_q.push_back(DW'(i));
    base = n_acc;
    ext_mode = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      ext_start = 1'b1;
      tick(10);
      check("s5_step", 64'(n_acc - base), 64'(k));
      ext_start = 1'b0;
      tick(2);
    end
    check("s5_done", 64'(stim_done), 1);
    check("s5_pass", 64'(stim_pass_count), 1);

    // overfill, full pass, reset mid-DRIVE
    clear();
    for (int i = 0; i < DEPTH + 3; i++)
      load(ent(1'b1, 0, 100 + i));
    check("s6_wrcnt", 64'(wr_count), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back(DW'(100 + i));
    base = n_acc;
    run(2'b00, 0);
    wait_done("s6_done", 200);
    check("s6_nacc", 64'(n_acc - base), DEPTH);
    check("s6_left", 64'(exp_q.size()), 0);
    u_if.dut_ready = 1'b0;
    run(2'b00, 0);
    wait_valid("s6_valid", 20);
    check("s6_pkt0", 64'(u_if.stim_packet), 100);
    #2 nreset = 1'b0;
    #1;
    check("s6_rst_valid", 64'(u_if.stim_valid), 0);
    check("s6_rst_busy", 64'(stim_busy), 0);
    check("s6_rst_wrcnt", 64'(wr_count), 0);
    tick(1);
    nreset = 1'b1;
    tick(1);
    for (int i = 0; i < DEPTH; i++)
      load(ent(1'b1, 0, 100 + i));
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back(DW'(100 + i));
    u_if.dut_ready = 1'b1;
    base = n_acc;
    run(2'b00, 0);
    wait_done("s6_re_done", 200);
    check("s6_re_nacc", 64'(n_acc - base), DEPTH);
    check("s6_re_pass", 64'(stim_pass_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
